adc_spi_sequencer: RTL and testbench

- Controller in front of the ADC SPI master. It sequences the fast-ADC power-up programming: it walks a synchronous register-write table and issues each word as one SPI transfer.
- After the init sequence completes, it grants single host-initiated transfers (register write/readback) to the shared SPI master.
- It owns the SPI master's trigger/data_in and watches its ready/data_out. It handles the ready-latency handshake, inter-transfer chip-select gap, and a timeout.

---
 rtl/adc_spi_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_adc_spi_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sequencer.sv
// Purpose: sequences fast-ADC power-up register writes from a table through a shared SPI master, then grants single host transfers.
// Latency: start sampled at edge 0 -> spi_trigger_out high after edge 2; host request -> trigger one cycle after acceptance.
// Backpressure: waits on SPI master ready (low then high) with timeout; host req_in is held off until init completes successfully.
// Optional: define ADC_SPI_SEQ_AUTOSTART_EN to start the init sequence automatically on the first cycle after reset release.
`timescale 1ns/1ps
module adc_spi_sequencer #(
    parameter int TRANSFER_SIZE  = 16,
    parameter int NUM_WORDS      = 8,
    parameter int ADDR_W         = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    output logic [ADDR_W-1:0]        tbl_addr_out,
    input  logic [TRANSFER_SIZE-1:0] tbl_data_in,
    input  logic                     req_in,
    input  logic [TRANSFER_SIZE-1:0] req_data_in,
    output logic                     req_ack_out,
    output logic [TRANSFER_SIZE-1:0] req_rdata_out,
    output logic                     spi_trigger_out,
    output logic [TRANSFER_SIZE-1:0] spi_data_out,
    input  logic [TRANSFER_SIZE-1:0] spi_data_in,
    input  logic                     spi_ready_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     error_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_TRIG    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    // Counter reload values: both counters count down to zero inclusive,
    // so loading N-1 gives exactly N cycles in the counted state.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [15:0]       TO_LOAD  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          idx_q, idx_d;
    logic                       host_q, host_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;
    logic                       ack_q, ack_d;
    logic [TRANSFER_SIZE-1:0]   rdata_q, rdata_d;
    logic [TRANSFER_SIZE-1:0]   sdat_q, sdat_d;
    logic [15:0]                to_cnt_q, to_cnt_d;
    logic [7:0]                 gap_cnt_q, gap_cnt_d;
    logic                       start_eff;

`ifdef ADC_SPI_SEQ_AUTOSTART_EN
    logic auto_q;

    // Remember that reset was active last cycle; that cycle-late flag is the internal start pulse.
    always_ff @(posedge clk_in) begin
        auto_q <= rst_in;
    end

    assign start_eff = start_in | auto_q;
`else
    assign start_eff = start_in;
`endif

    // Next-state and datapath decisions; every register holds unless a state says otherwise.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        host_d    = host_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        ack_d     = 1'b0;
        rdata_d   = rdata_q;
        sdat_d    = sdat_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Start has priority; a simultaneous host request simply stays
                // pending and is served once the new sequence sets done again.
                if (start_eff) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    host_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (req_in && done_q) begin
                    state_d = S_TRIG;
                    sdat_d  = req_data_in;
                    host_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            // Registered table ROM needs one cycle after the address moves.
            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                sdat_d  = tbl_data_in;
                state_d = S_TRIG;
            end

            S_TRIG: begin
                to_cnt_d = TO_LOAD;
                state_d  = S_WAIT_LO;
            end

            // The master still shows the previous ready=1 during the trigger
            // cycle, so completion is only recognised after ready has dropped.
            S_WAIT_LO: begin
                if (to_cnt_q != '0) begin
                    to_cnt_d = to_cnt_q - 16'd1;
                end
                if (!spi_ready_in) begin
                    state_d = S_WAIT_HI;
                end else if (to_cnt_q == '0) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    host_d  = 1'b0;
                end
            end

            S_WAIT_HI: begin
                if (to_cnt_q != '0) begin
                    to_cnt_d = to_cnt_q - 16'd1;
                end
                if (spi_ready_in) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                    if (host_q) begin
                        rdata_d = spi_data_in;
                        ack_d   = 1'b1;
                    end
                end else if (to_cnt_q == '0) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    host_d  = 1'b0;
                end
            end

            // Chip-select idle time; host_q is kept until here so the exit
            // can tell a host transfer from an init word.
            S_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (host_q) begin
                    state_d = S_IDLE;
                    host_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            host_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            sdat_q    <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            host_q    <= host_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            sdat_q    <= sdat_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Trigger is gated by reset so an in-flight pulse dies in the reset cycle itself.
    assign spi_trigger_out = (state_q == S_TRIG) && !rst_in;
    assign spi_data_out    = sdat_q;
    assign tbl_addr_out    = idx_q;
    assign req_ack_out     = ack_q;
    assign req_rdata_out   = rdata_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign error_out       = error_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Purpose: scoreboard bench for adc_spi_sequencer with a behavioural SPI master and registered table ROM.
// Latency: expected trigger words are queued at stimulus time and popped on each observed trigger.
// Backpressure: SPI master model holds ready low for a fixed transfer time, or forever in hang mode.
`timescale 1ns/1ps
module tb_adc_spi_sequencer;

    localparam int TS   = 16;
    localparam int NW   = 3;
    localparam int AW   = 8;
    localparam int GAP  = 4;
    localparam int TO   = 16;
    localparam int XFER = 8;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            start_in = 1'b0;
    logic [AW-1:0]   tbl_addr_out;
    logic [TS-1:0]   tbl_data_in = '0;
    logic            req_in = 1'b0;
    logic [TS-1:0]   req_data_in = '0;
    logic            req_ack_out;
    logic [TS-1:0]   req_rdata_out;
    logic            spi_trigger_out;
    logic [TS-1:0]   spi_data_out;
    logic [TS-1:0]   spi_data_in = '0;
    logic            spi_ready_in = 1'b0;
    logic            busy_out;
    logic            done_out;
    logic            error_out;

    always #5 clk_in = ~clk_in;

    adc_spi_sequencer #(
        .TRANSFER_SIZE (TS),
        .NUM_WORDS     (NW),
        .ADDR_W        (AW),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .tbl_addr_out   (tbl_addr_out),
        .tbl_data_in    (tbl_data_in),
        .req_in         (req_in),
        .req_data_in    (req_data_in),
        .req_ack_out    (req_ack_out),
        .req_rdata_out  (req_rdata_out),
        .spi_trigger_out(spi_trigger_out),
        .spi_data_out   (spi_data_out),
        .spi_data_in    (spi_data_in),
        .spi_ready_in   (spi_ready_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int trig_cnt = 0;
    int ack_cnt = 0;
    int trig_dbl = 0;
    int addr_bad = 0;
    int rise_cyc = 0;
    logic rise_seen = 1'b0;
    logic prev_trig = 1'b0;
    logic prev_rdy = 1'b0;
    logic hang = 1'b0;
    logic [TS-1:0] exp_q[$];
    logic [TS-1:0] rom [0:NW-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rom[0] = 16'h8001;
        rom[1] = 16'h0203;
        rom[2] = 16'h0405;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // Registered ROM: data follows the address by one clock.
    always @(posedge clk_in) begin
        tbl_data_in <= (tbl_addr_out < AW'(NW)) ? rom[tbl_addr_out[1:0]] : 16'hDEAD;
    end

    // SPI master model with loopback: returns the word it was given.
    int unsigned busy_cnt = 0;
    logic [TS-1:0] shreg = '0;
    always @(posedge clk_in) begin
        if (rst_in) begin
            spi_ready_in <= 1'b1;
            busy_cnt     <= 0;
            spi_data_in  <= '0;
            shreg        <= '0;
        end else if (spi_ready_in) begin
            if (spi_trigger_out) begin
                spi_ready_in <= 1'b0;
                busy_cnt     <= XFER;
                shreg        <= spi_data_out;
            end
        end else if (busy_cnt > 1 || hang) begin
            if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
        end else begin
            spi_ready_in <= 1'b1;
            spi_data_in  <= shreg;
            busy_cnt     <= 0;
        end
    end

    // Monitor: scoreboard pops on each trigger, plus gap/pulse/address watches.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (spi_trigger_out) begin
                trig_cnt++;
                if (prev_trig) trig_dbl++;
                if (rise_seen) begin
                    check("cs_gap", ((cyc - rise_cyc) >= GAP), 1'b1);
                    rise_seen = 1'b0;
                end
                check("sb_has_exp", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) check("trig_dat", spi_data_out, exp_q.pop_front());
            end
            if (spi_ready_in && !prev_rdy) begin
                rise_cyc  = cyc;
                rise_seen = 1'b1;
            end
            if (req_ack_out) ack_cnt++;
            if (tbl_addr_out > AW'(NW - 1)) addr_bad++;
        end
        prev_trig = spi_trigger_out;
        prev_rdy  = spi_ready_in;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push_init();
        for (int i = 0; i < NW; i++) exp_q.push_back(rom[i]);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick(1);
        start_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_out && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, busy_out, 1'b0);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (!req_ack_out && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_ack"}, req_ack_out, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_err"}, error_out, 0);
        check({tag, "_trig"}, spi_trigger_out, 0);
        check({tag, "_ack"}, req_ack_out, 0);
        check({tag, "_addr"}, tbl_addr_out, 0);
        check({tag, "_sdat"}, spi_data_out, 0);
        check({tag, "_rdat"}, req_rdata_out, 0);
    endtask

    initial begin
        int t0, a0, k, n, tt, te;

        // Reset state.
        tick(3);
        check_all_zero("rst");

`ifdef ADC_SPI_SEQ_AUTOSTART_EN
        // Sequence must run on its own after reset release.
        push_init();
        rst_in = 1'b0;
        tick(2);
        wait_idle("auto", 500);
        check("auto_done", done_out, 1);
        check("auto_trigs", trig_cnt, NW);
        check("auto_sb_empty", exp_q.size(), 0);
`else
        // No autostart; an early host request is held off and never acked.
        rst_in = 1'b0;
        tick(2);
        req_data_in = 16'h5555;
        req_in      = 1'b1;
        tick(1000);
        req_in = 1'b0;
        check("noauto_trigs", trig_cnt, 0);
        check("early_req_ack", ack_cnt, 0);
        check("noauto_busy", busy_out, 0);
`endif

        // Init sequence, with a stray start while busy that must be ignored.
        t0 = trig_cnt;
        push_init();
        pulse_start();
        check("init_busy", busy_out, 1);
        tick(5);
        pulse_start();
        wait_idle("init", 500);
        check("init_done", done_out, 1);
        check("init_err", error_out, 0);
        check("init_trigs", trig_cnt - t0, NW);
        check("init_sb_empty", exp_q.size(), 0);

        // Host loopback transfer.
        t0 = trig_cnt;
        a0 = ack_cnt;
        exp_q.push_back(16'h80AB);
        req_data_in = 16'h80AB;
        req_in      = 1'b1;
        wait_ack("host", 200);
        req_in = 1'b0;
        check("host_rdata", req_rdata_out, 16'h80AB);
        wait_idle("host", 100);
        tick(3);
        check("host_ack_cnt", ack_cnt - a0, 1);
        check("host_trigs", trig_cnt - t0, 1);
        check("host_done_kept", done_out, 1);

        // Start and request together: init first, then one host transfer.
        t0 = trig_cnt;
        a0 = ack_cnt;
        push_init();
        exp_q.push_back(16'h1234);
        req_data_in = 16'h1234;
        req_in      = 1'b1;
        pulse_start();
        wait_ack("both", 800);
        req_in = 1'b0;
        check("both_rdata", req_rdata_out, 16'h1234);
        wait_idle("both", 100);
        tick(3);
        check("both_ack_cnt", ack_cnt - a0, 1);
        check("both_trigs", trig_cnt - t0, NW + 1);
        check("both_done", done_out, 1);
        check("both_sb_empty", exp_q.size(), 0);

        // Reset in the trigger cycle of word 2, then replay from address 0.
        push_init();
        pulse_start();
        k = 0;
        n = 0;
        while (k < 2 && n < 300) begin
            tick(1);
            n++;
            if (spi_trigger_out) k++;
        end
        check("rst_reach_w2", k, 2);
        rst_in = 1'b1;
        #1;
        check("rst_trig_drop", spi_trigger_out, 0);
        @(posedge clk_in);
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        tick(1);
        rst_in = 1'b0;
        tick(2);
        t0 = trig_cnt;
        push_init();
        pulse_start();
        wait_idle("replay", 500);
        check("replay_done", done_out, 1);
        check("replay_trigs", trig_cnt - t0, NW);
        check("replay_sb_empty", exp_q.size(), 0);

        // Timeout: master never returns ready.
        hang = 1'b1;
        exp_q.push_back(16'h8001);
        t0 = trig_cnt;
        a0 = ack_cnt;
        pulse_start();
        n = 0;
        while (!spi_trigger_out && n < 50) begin
            tick(1);
            n++;
        end
        tt = cyc;
        n = 0;
        while (!error_out && n < 100) begin
            tick(1);
            n++;
        end
        te = cyc;
        check("to_error", error_out, 1);
        check("to_delay", te - tt, 17);
        check("to_done", done_out, 0);
        check("to_busy", busy_out, 0);
        tick(30);
        req_data_in = 16'h0F0F;
        req_in      = 1'b1;
        tick(50);
        req_in = 1'b0;
        check("to_no_ack", ack_cnt - a0, 0);
        check("to_trigs", trig_cnt - t0, 1);
        check("to_busy_after", busy_out, 0);
        hang   = 1'b0;
        rst_in = 1'b1;
        tick(2);
        check("to_rst_err", error_out, 0);
        rst_in = 1'b0;
        tick(2);

        check("single_pulse", trig_dbl, 0);
        check("addr_range", addr_bad, 0);
        check("sb_final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
